// File: rtl/store_buffer.sv
// FIFO store buffer between EX/MEM and dmem, with word-granular load hazard detection.
// Optional store-to-load forwarding of word stores: define STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    st_size,
  input  logic [31:0]   st_pc,
  output logic          st_err,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_stall,
  input  logic          drain_hold,
  input  logic          fence,
  output logic          fence_done,
  output logic          MemWr,
  output logic [1:0]    store,
  output logic [31:0]   ALUout,
  output logic [31:0]   MemData,
  output logic [31:0]   PC,
`ifdef STORE_BUFFER_FWD_EN
  output logic          fwd_valid,
  output logic [31:0]   fwd_data,
`endif
  output logic [AW:0]   count
);

  logic [31:0]      e_addr [DEPTH];
  logic [31:0]      e_data [DEPTH];
  logic [1:0]       e_size [DEPTH];
  logic [31:0]      e_pc   [DEPTH];
  logic [DEPTH-1:0] e_valid;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, bad_size;

  assign st_ready   = (count != (AW+1)'(DEPTH)) && !fence;
  assign bad_size   = st_valid && st_ready && (st_size == 2'b11);
  assign push       = st_valid && st_ready && (st_size != 2'b11);
  assign pop        = (count != '0) && !drain_hold;
  assign fence_done = fence && (count == '0) && !MemWr;

  always_ff @(posedge clk) begin
    if (push) begin
      e_addr[wr_ptr] <= st_addr;
      e_data[wr_ptr] <= st_data;
      e_size[wr_ptr] <= st_size;
      e_pc[wr_ptr]   <= st_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      e_valid <= '0;
      MemWr   <= 1'b0;
      store   <= '0;
      ALUout  <= '0;
      MemData <= '0;
      PC      <= '0;
      st_err  <= 1'b0;
    end else begin
      st_err <= bad_size;
      MemWr  <= pop;
      if (push) begin
        e_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        e_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
        store           <= e_size[rd_ptr];
        ALUout          <= e_addr[rd_ptr];
        MemData         <= e_data[rd_ptr];
        PC              <= e_pc[rd_ptr];
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  logic          hit, out_hit;
  logic [AW-1:0] idx;
`ifdef STORE_BUFFER_FWD_EN
  logic          young_word;
  logic [31:0]   young_data;
`endif

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    young_word = 1'b0;
    young_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (e_valid[idx] && (e_addr[idx][31:2] == ld_addr[31:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        young_word = (e_size[idx] == 2'b00);
        young_data = e_data[idx];
`endif
      end
    end
  end

  assign out_hit = MemWr && (ALUout[31:2] == ld_addr[31:2]);

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_valid = ld_valid && hit && young_word;
  assign fwd_data  = fwd_valid ? young_data : '0;
  assign ld_stall  = ld_valid && (hit ? !young_word : out_hit);
`else
  assign ld_stall  = ld_valid && (hit || out_hit);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset, st_valid, ld_valid, drain_hold, fence;
  logic        st_ready, st_err, ld_stall, fence_done, MemWr;
  logic [31:0] st_addr, st_data, st_pc, ld_addr;
  logic [1:0]  st_size, store;
  logic [31:0] ALUout, MemData, PC;
  logic [2:0]  count;
`ifdef STORE_BUFFER_FWD_EN
  logic        fwd_valid;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;
  int pulses;

  store_buffer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_pc(st_pc), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .drain_hold(drain_hold), .fence(fence), .fence_done(fence_done),
    .MemWr(MemWr), .store(store), .ALUout(ALUout), .MemData(MemData), .PC(PC),
`ifdef STORE_BUFFER_FWD_EN
    .fwd_valid(fwd_valid), .fwd_data(fwd_data),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s; st_pc = a + 32'h1000;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; st_valid = 0; ld_valid = 0; drain_hold = 0; fence = 0;
    st_addr = '0; st_data = '0; st_size = '0; st_pc = '0; ld_addr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_count", count, 0);
    check_eq("rst_memwr", MemWr, 0);
    check_eq("rst_aluout", ALUout, 0);
    check_eq("rst_memdata", MemData, 0);
    check_eq("rst_pc", PC, 0);
    check_eq("rst_st_err", st_err, 0);
    check_eq("rst_ready", st_ready, 1);

    // single store latency
    st_valid = 1; st_addr = 32'h10; st_data = 32'hDEADBEEF; st_size = 2'b00; st_pc = 32'h100;
    #1 check_eq("t1_ready", st_ready, 1);
    tick(); st_valid = 0;
    check_eq("t1_landed_count", count, 1);
    check_eq("t1_landed_memwr", MemWr, 0);
    tick();
    check_eq("t1_memwr", MemWr, 1);
    check_eq("t1_aluout", ALUout, 32'h10);
    check_eq("t1_memdata", MemData, 32'hDEADBEEF);
    check_eq("t1_store", store, 0);
    check_eq("t1_pc", PC, 32'h100);
    check_eq("t1_count", count, 0);
    tick();
    check_eq("t1_memwr_off", MemWr, 0);
    check_eq("t1_hold_data", MemData, 32'hDEADBEEF);

    // fill under hold, reject fifth, drain in order
    drain_hold = 1;
    for (int k = 0; k < 4; k++) push_st(32'(k * 4), 32'hA0 + 32'(k), 2'b00);
    check_eq("t2_full_count", count, 4);
    check_eq("t2_full_ready", st_ready, 0);
    st_valid = 1; st_addr = 32'h30; st_data = 32'h55; st_size = 2'b00;
    tick(); st_valid = 0;
    check_eq("t2_fifth_rejected", count, 4);
    drain_hold = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t2_memwr%0d", k), MemWr, 1);
      check_eq($sformatf("t2_addr%0d", k), ALUout, 32'(k * 4));
      check_eq($sformatf("t2_data%0d", k), MemData, 32'hA0 + 32'(k));
      check_eq($sformatf("t2_pc%0d", k), PC, 32'(k * 4) + 32'h1000);
    end
    tick();
    check_eq("t2_done_memwr", MemWr, 0);
    check_eq("t2_done_count", count, 0);

    // hazard detection / forwarding
    drain_hold = 1;
    push_st(32'h21, 32'hAB, 2'b10);
    ld_valid = 1; ld_addr = 32'h22;
    #1 check_eq("t3_stall_same_word", ld_stall, 1);
    ld_addr = 32'h24;
    #1 check_eq("t3_nostall_next_word", ld_stall, 0);
    ld_valid = 0;
    #1 check_eq("t3_nostall_no_load", ld_stall, 0);
    push_st(32'h20, 32'h11223344, 2'b00);
    ld_valid = 1; ld_addr = 32'h20;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check_eq("t3_fwd_valid", fwd_valid, 1);
    check_eq("t3_fwd_data", fwd_data, 32'h11223344);
    check_eq("t3_fwd_nostall", ld_stall, 0);
`else
    check_eq("t3_word_stall", ld_stall, 1);
`endif
    drain_hold = 0;
    tick();
    check_eq("t3_pop1_addr", ALUout, 32'h21);
    check_eq("t3_pop1_store", store, 2'b10);
    tick();
    check_eq("t3_pop2_addr", ALUout, 32'h20);
    check_eq("t3_pop2_count", count, 0);
    check_eq("t3_stall_on_memwr", ld_stall, 1);
    tick();
    check_eq("t3_nostall_after", ld_stall, 0);
    ld_valid = 0;

    // illegal size
    st_valid = 1; st_addr = 32'h40; st_data = 32'h77; st_size = 2'b11;
    tick(); st_valid = 0;
    check_eq("t4_err_pulse", st_err, 1);
    check_eq("t4_count", count, 0);
    tick();
    check_eq("t4_err_clear", st_err, 0);
    check_eq("t4_no_memwr", MemWr, 0);
    check_eq("t4_count2", count, 0);

    // reset discards pending stores
    drain_hold = 1;
    for (int k = 0; k < 3; k++) push_st(32'h60 + 32'(k * 4), 32'hC0 + 32'(k), 2'b00);
    check_eq("t5_pending", count, 3);
    reset = 1; drain_hold = 0;
    tick();
    reset = 0;
    check_eq("t5_count", count, 0);
    check_eq("t5_aluout", ALUout, 0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (MemWr) pulses++;
    end
    check_eq("t5_no_memwr", 32'(pulses), 0);

    // fence drain
    drain_hold = 1;
    push_st(32'h50, 32'hE0, 2'b00);
    push_st(32'h54, 32'hE1, 2'b00);
    fence = 1; drain_hold = 0;
    #1;
    check_eq("t6_ready0", st_ready, 0);
    check_eq("t6_done0", fence_done, 0);
    tick();
    check_eq("t6_memwr1", MemWr, 1);
    check_eq("t6_addr1", ALUout, 32'h50);
    check_eq("t6_ready1", st_ready, 0);
    check_eq("t6_done1", fence_done, 0);
    tick();
    check_eq("t6_memwr2", MemWr, 1);
    check_eq("t6_addr2", ALUout, 32'h54);
    check_eq("t6_ready2", st_ready, 0);
    check_eq("t6_done2", fence_done, 0);
    tick();
    check_eq("t6_done3", fence_done, 1);
    check_eq("t6_ready3", st_ready, 0);
    fence = 0;
    #1 check_eq("t6_done_clear", fence_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
